// File: rtl/countdown_timer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | countdown_timer                                                           |
// | Preset mm:ss countdown in centisecond steps with six 7-segment digits.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module countdown_timer #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       set_min,
  input  logic       set_sec,
  input  logic       clr,
  output logic [6:0] m10,
  output logic [6:0] m1,
  output logic [6:0] s10,
  output logic [6:0] s1,
  output logic [6:0] c10,
  output logic [6:0] c1,
  output logic       running,
  output logic       alarm
);

  localparam int                 c_pre_w    = $clog2(TICK_DIV);
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
  localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_pause = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]         r_state, w_next_state;
  logic [6:0]         r_min, w_min_nx, w_dec_min;
  logic [5:0]         r_sec, w_sec_nx, w_dec_sec;
  logic [6:0]         r_cs, w_cs_nx, w_dec_cs;
  logic [c_pre_w-1:0] r_pre, w_pre_nx;
  logic               r_ss_prev, r_min_prev, r_sec_prev;
  logic               r_running, r_alarm;
  logic               w_ss_edge, w_min_edge, w_sec_edge;
  logic               w_tick, w_time_zero, w_dec_zero;

  function automatic logic [6:0] f_seg(input logic [6:0] d);
    case (d)
      7'd0:    f_seg = 7'h3F;
      7'd1:    f_seg = 7'h06;
      7'd2:    f_seg = 7'h5B;
      7'd3:    f_seg = 7'h4F;
      7'd4:    f_seg = 7'h66;
      7'd5:    f_seg = 7'h6D;
      7'd6:    f_seg = 7'h7D;
      7'd7:    f_seg = 7'h07;
      7'd8:    f_seg = 7'h7F;
      7'd9:    f_seg = 7'h6F;
      default: f_seg = 7'h00;
    endcase
  endfunction

  // Prev flops reset high so a button held through reset yields no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_prev  <= 1'b1;
      r_min_prev <= 1'b1;
      r_sec_prev <= 1'b1;
    end else begin
      r_ss_prev  <= start_stop;
      r_min_prev <= set_min;
      r_sec_prev <= set_sec;
    end
  end

  assign w_ss_edge  = start_stop & ~r_ss_prev;
  assign w_min_edge = set_min & ~r_min_prev;
  assign w_sec_edge = set_sec & ~r_sec_prev;

  // Borrow chain; only consumed in RUN, where the time is never zero.
  always_comb begin
    w_tick      = (r_state == c_run) && (r_pre == c_pre_last);
    w_time_zero = (r_min == 7'd0) && (r_sec == 6'd0) && (r_cs == 7'd0);
    w_dec_min   = r_min;
    w_dec_sec   = r_sec;
    w_dec_cs    = r_cs;
    if (r_cs != 7'd0) begin
      w_dec_cs = r_cs - 7'd1;
    end else begin
      w_dec_cs = 7'd99;
      if (r_sec != 6'd0) begin
        w_dec_sec = r_sec - 6'd1;
      end else begin
        w_dec_sec = 6'd59;
        w_dec_min = r_min - 7'd1;
      end
    end
    w_dec_zero = (w_dec_min == 7'd0) && (w_dec_sec == 6'd0) && (w_dec_cs == 7'd0);
  end

  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = c_idle;
    end else begin
      case (r_state)
        c_idle:  if (w_ss_edge && !w_time_zero) w_next_state = c_run;
        c_run: begin
          if (w_tick && w_dec_zero) w_next_state = c_done;
          else if (w_ss_edge)       w_next_state = c_pause;
        end
        c_pause: if (w_ss_edge) w_next_state = c_run;
        default: if (w_ss_edge) w_next_state = c_idle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_idle;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_running <= (w_next_state == c_run);
      r_alarm   <= (w_next_state == c_done);
    end
  end

  // Pausing on a non-tick cycle holds pre so the partial tick survives.
  always_comb begin
    w_min_nx = r_min;
    w_sec_nx = r_sec;
    w_cs_nx  = r_cs;
    w_pre_nx = r_pre;
    if (clr) begin
      w_min_nx = 7'd0;
      w_sec_nx = 6'd0;
      w_cs_nx  = 7'd0;
      w_pre_nx = '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_min_edge) w_min_nx = (r_min == 7'd99) ? 7'd0 : r_min + 7'd1;
          if (w_sec_edge) w_sec_nx = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
          w_pre_nx = '0;
        end
        c_run: begin
          if (w_tick) begin
            w_min_nx = w_dec_min;
            w_sec_nx = w_dec_sec;
            w_cs_nx  = w_dec_cs;
            w_pre_nx = '0;
          end else if (!w_ss_edge) begin
            w_pre_nx = r_pre + c_pre_one;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min <= 7'd0;
      r_sec <= 6'd0;
      r_cs  <= 7'd0;
      r_pre <= '0;
    end else begin
      r_min <= w_min_nx;
      r_sec <= w_sec_nx;
      r_cs  <= w_cs_nx;
      r_pre <= w_pre_nx;
    end
  end

  always_comb begin
    m10     = f_seg(r_min / 7'd10);
    m1      = f_seg(r_min % 7'd10);
    s10     = f_seg({1'b0, r_sec} / 7'd10);
    s1      = f_seg({1'b0, r_sec} % 7'd10);
    c10     = f_seg(r_cs / 7'd10);
    c1      = f_seg(r_cs % 7'd10);
    running = r_running;
    alarm   = r_alarm;
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_countdown_timer                                                        |
// | Directed vector table plus hand sequences for countdown_timer.            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst, start_stop, set_min, set_sec, clr;
  logic [6:0] m10, m1, s10, s1, c10, c1;
  logic running, alarm;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // in = {start_stop, set_min, set_sec, clr}; st = {running, alarm}
  typedef struct {
    logic [3:0] in;
    int         em;
    int         es;
    int         ec;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [28];

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .set_min(set_min),
    .set_sec(set_sec), .clr(clr), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .c10(c10), .c1(c1), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int em, input int es, input int ec,
                       input logic er, input logic ea);
    logic [41:0] exp_d, act_d;
    exp_d = {pat[em/10], pat[em%10], pat[es/10], pat[es%10], pat[ec/10], pat[ec%10]};
    act_d = {m10, m1, s10, s1, c10, c1};
    n_checks++;
    if (act_d !== exp_d || running !== er || alarm !== ea) begin
      n_errors++;
      $display("FAIL %s: got digits=%h running=%b alarm=%b, expected digits=%h running=%b alarm=%b",
               nm, act_d, running, alarm, exp_d, er, ea);
    end
  endtask

  task automatic press_min();
    set_min = 1'b1; step(1); set_min = 1'b0; step(1);
  endtask

  task automatic press_sec();
    set_sec = 1'b1; step(1); set_sec = 1'b0; step(1);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; step(1); clr = 1'b0; step(1);
  endtask

  initial begin
    vecs = '{
      '{4'b0000, 0, 0,  0, 2'b00},  // idle
      '{4'b1000, 0, 0,  0, 2'b00},  // start at zero ignored
      '{4'b0000, 0, 0,  0, 2'b00},
      '{4'b0100, 1, 0,  0, 2'b00},
      '{4'b0010, 1, 1,  0, 2'b00},
      '{4'b0100, 2, 1,  0, 2'b00},
      '{4'b0110, 2, 2,  0, 2'b00},  // min held, sec edge
      '{4'b0000, 2, 2,  0, 2'b00},
      '{4'b0110, 3, 3,  0, 2'b00},  // both edges together
      '{4'b0000, 3, 3,  0, 2'b00},
      '{4'b0101, 0, 0,  0, 2'b00},  // clr beats set_min edge
      '{4'b0100, 0, 0,  0, 2'b00},  // still held: no edge
      '{4'b0000, 0, 0,  0, 2'b00},
      '{4'b0010, 0, 1,  0, 2'b00},
      '{4'b0000, 0, 1,  0, 2'b00},
      '{4'b1000, 0, 1,  0, 2'b10},  // RUN, pre=0
      '{4'b1000, 0, 1,  0, 2'b10},
      '{4'b0000, 0, 1,  0, 2'b10},
      '{4'b0000, 0, 1,  0, 2'b10},
      '{4'b0000, 0, 0, 99, 2'b10},  // first tick
      '{4'b1000, 0, 0, 99, 2'b00},  // pause
      '{4'b0000, 0, 0, 99, 2'b00},
      '{4'b1000, 0, 0, 99, 2'b10},  // resume
      '{4'b0000, 0, 0, 99, 2'b10},
      '{4'b0000, 0, 0, 99, 2'b10},
      '{4'b0000, 0, 0, 99, 2'b10},
      '{4'b0000, 0, 0, 98, 2'b10},
      '{4'b0001, 0, 0,  0, 2'b00}   // clr from RUN
    };

    rst = 1'b1; start_stop = 1'b0; set_min = 1'b1; set_sec = 1'b0; clr = 1'b0;
    step(2);
    rst = 1'b0;
    check("reset_state", 0, 0, 0, 1'b0, 1'b0);
    step(2);
    check("min_held_through_reset", 0, 0, 0, 1'b0, 1'b0);
    set_min = 1'b0;
    step(1);

    foreach (vecs[i]) begin
      {start_stop, set_min, set_sec, clr} = vecs[i].in;
      step(1);
      check($sformatf("vec%0d", i), vecs[i].em, vecs[i].es, vecs[i].ec,
            vecs[i].st[1], vecs[i].st[0]);
    end
    {start_stop, set_min, set_sec, clr} = 4'b0000;
    step(1);

    // 3 min + 61 sec presses
    do_clr();
    repeat (3) press_min();
    repeat (61) press_sec();
    check("set_03_01", 3, 1, 0, 1'b0, 1'b0);

    // Run from 01:00.00 with borrow
    do_clr();
    press_min();
    pulse_ss();
    step(3);
    check("run_before_tick", 1, 0, 0, 1'b1, 1'b0);
    step(1);
    check("borrow_59_99", 0, 59, 99, 1'b1, 1'b0);
    step(4);
    check("second_tick", 0, 59, 98, 1'b1, 1'b0);

    // Run 00:01.00 down to DONE
    do_clr();
    press_sec();
    pulse_ss();
    step(392);
    check("at_00_00_02", 0, 0, 2, 1'b1, 1'b0);
    step(7);
    check("before_done", 0, 0, 1, 1'b1, 1'b0);
    step(1);
    check("done", 0, 0, 0, 1'b0, 1'b1);
    step(1);
    pulse_ss();
    check("done_ack_idle", 0, 0, 0, 1'b0, 1'b0);

    // Pause 2 cycles into a tick
    do_clr();
    press_sec();
    pulse_ss();
    step(2);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(100);
    check("paused_frozen", 0, 1, 0, 1'b0, 1'b0);
    pulse_ss();
    check("resumed", 0, 1, 0, 1'b1, 1'b0);
    step(1);
    check("resume_plus1", 0, 1, 0, 1'b1, 1'b0);
    step(1);
    check("resume_plus2_tick", 0, 0, 99, 1'b1, 1'b0);

    // clr on tick cycle with start_stop edge
    do_clr();
    press_sec();
    pulse_ss();
    step(3);
    clr = 1'b1; start_stop = 1'b1;
    step(1);
    check("clr_tick_ss", 0, 0, 0, 1'b0, 1'b0);
    clr = 1'b0; start_stop = 1'b0;
    step(1);
    check("clr_stays_idle", 0, 0, 0, 1'b0, 1'b0);

    // Tick + start_stop at non-zero: decrement and pause
    do_clr();
    press_sec();
    pulse_ss();
    step(3);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("tick_ss_pause", 0, 0, 99, 1'b0, 1'b0);
    step(8);
    check("tick_ss_pause_hold", 0, 0, 99, 1'b0, 1'b0);

    // Tick + start_stop reaching zero: DONE wins
    do_clr();
    press_sec();
    pulse_ss();
    step(399);
    check("at_00_00_01", 0, 0, 1, 1'b1, 1'b0);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("zero_ss_done", 0, 0, 0, 1'b0, 1'b1);
    step(1);

    // Minutes wrap 99 -> 0
    do_clr();
    repeat (99) press_min();
    check("min_99", 99, 0, 0, 1'b0, 1'b0);
    press_min();
    check("min_wrap", 0, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN
    do_clr();
    press_sec();
    pulse_ss();
    step(5);
    check("pre_async_run", 0, 0, 99, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_reset", 0, 0, 0, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    step(2);
    check("after_async_reset", 0, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
